// File: rtl/pipe_hazard_ctrl.sv
// Hazard control: RAW scoreboard, redirect flush sequencing and
// memory-busy freeze for a single-issue in-order pipeline.
module pipe_hazard_ctrl #(
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int WB_DIST                = 2,
  parameter int FLUSH_CYCLES           = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              id_valid_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rs1_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rs2_i,
  input  logic                              id_use_rs1_i,
  input  logic                              id_use_rs2_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rd_i,
  input  logic                              id_reg_write_i,
  input  logic                              ex_redirect_i,
  input  logic                              mem_busy_i,
  output logic                              issue_o,
  output logic                              stall_o,
  output logic                              flush_o,
  output logic                              freeze_o,
  output logic [15:0]                       stall_cnt_o
);

  localparam int          NREG   = 1 << PROC_REGFILE_LOG2_DEEP;
  localparam logic [1:0]  WB     = 2'(WB_DIST);
  localparam logic [1:0]  FL_RLD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, FLUSH, FROZEN} state_e;

  state_e      state_q, state_d, ret_q, ret_d, eff;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [1:0]  pend_q [NREG];
  logic [1:0]  pend_d [NREG];
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        raw, redir;

  // A thawing cycle behaves as the state that was frozen.
  assign eff   = (state_q == FROZEN) ? ret_q : state_q;
  assign redir = ex_redirect_i & (state_q != FROZEN);

  assign raw = id_valid_i &
    ((id_use_rs1_i & (id_rs1_i != '0) & (pend_q[id_rs1_i] != 2'd0)) |
     (id_use_rs2_i & (id_rs2_i != '0) & (pend_q[id_rs2_i] != 2'd0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    fcnt_d  = fcnt_q;
    if (mem_busy_i) begin
      state_d = FROZEN;
      ret_d   = eff;
    end else begin
      state_d = eff;
      case (eff)
        RUN: begin
          if (redir && FL_RLD != 2'd0) begin
            state_d = FLUSH;
            fcnt_d  = FL_RLD;
          end
        end
        FLUSH: begin
          if (redir) begin
            fcnt_d = FL_RLD;
          end else if (fcnt_q <= 2'd1) begin
            state_d = RUN;
            fcnt_d  = 2'd0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    freeze_o = mem_busy_i;
    flush_o  = !mem_busy_i &
               ((eff == FLUSH) | ((eff == RUN) & redir));
    stall_o  = raw & !flush_o & !freeze_o;
    issue_o  = id_valid_i & !raw & !flush_o & !freeze_o;
  end

  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (!freeze_o && pend_q[r] != 2'd0)
        pend_d[r] = pend_q[r] - 2'd1;
    end
    if (issue_o && id_reg_write_i && id_rd_i != '0)
      pend_d[id_rd_i] = WB;
    pend_d[0] = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= 2'd0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl: a cycle table plus
// hand sequences for reset aborts and counter saturation.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       red;
    logic       busy;
    logic [3:0] exp;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid_i, id_use_rs1_i, id_use_rs2_i, id_reg_write_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        ex_redirect_i, mem_busy_i;
  logic        issue_o, stall_o, flush_o, freeze_o;
  logic [15:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_reg_write_i(id_reg_write_i),
    .ex_redirect_i (ex_redirect_i),
    .mem_busy_i    (mem_busy_i),
    .issue_o       (issue_o),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .freeze_o      (freeze_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  function automatic vec_t mk(
    logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
    logic [4:0] rd, logic rw, logic red, logic busy,
    logic [3:0] exp, logic [15:0] cnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.red = red; t.busy = busy;
    t.exp = exp; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(vec_t t, logic rst);
    @(negedge clk);
    reset          = rst;
    id_valid_i     = t.v;
    id_rs1_i       = t.rs1;
    id_use_rs1_i   = t.u1;
    id_rs2_i       = t.rs2;
    id_use_rs2_i   = t.u2;
    id_rd_i        = t.rd;
    id_reg_write_i = t.rw;
    ex_redirect_i  = t.red;
    mem_busy_i     = t.busy;
    #1;
  endtask

  task automatic run(string nm, vec_t t);
    step(t, 1'b0);
    chk({nm, ".outs"}, 16'({issue_o, stall_o, flush_o, freeze_o}),
        16'(t.exp));
    chk({nm, ".cnt"}, stall_cnt_o, t.cnt);
  endtask

  initial begin
    // outs = {issue, stall, flush, freeze}
    tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 4'b1000, 0));
    tbl.push_back(mk(1, 5,1, 0,0, 6,1, 0,0, 4'b0100, 0));
    tbl.push_back(mk(1, 5,1, 0,0, 6,1, 0,0, 4'b0100, 1));
    tbl.push_back(mk(1, 5,1, 0,0, 6,1, 0,0, 4'b1000, 2));
    tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 4'b1000, 2));
    tbl.push_back(mk(1, 0,1, 5,0, 0,1, 0,0, 4'b1000, 2));
    tbl.push_back(mk(1, 0,1, 0,1, 9,1, 0,0, 4'b1000, 2));
    tbl.push_back(mk(1, 0,0, 0,0, 0,0, 1,0, 4'b0010, 2));
    tbl.push_back(mk(1, 9,1, 0,0, 0,0, 0,0, 4'b0010, 2));
    tbl.push_back(mk(1, 9,1, 0,0, 0,0, 0,0, 4'b1000, 2));
    tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 4'b1000, 2));
    tbl.push_back(mk(1, 5,1, 0,0, 0,0, 1,1, 4'b0001, 2));
    tbl.push_back(mk(1, 5,1, 0,0, 0,0, 1,0, 4'b0100, 2));
    tbl.push_back(mk(1, 5,1, 0,0, 0,0, 0,0, 4'b0100, 3));
    tbl.push_back(mk(1, 5,1, 0,0, 7,1, 0,0, 4'b1000, 4));
    tbl.push_back(mk(1, 0,0, 0,0, 0,0, 1,0, 4'b0010, 4));
    tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0,1, 4'b0001, 4));
    tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0,1, 4'b0001, 4));
    tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0,1, 4'b0001, 4));
    tbl.push_back(mk(1, 7,1, 0,0, 0,0, 0,0, 4'b0010, 4));
    tbl.push_back(mk(1, 7,1, 0,0, 0,0, 0,0, 4'b1000, 4));
    tbl.push_back(mk(0, 7,1, 0,0, 0,0, 0,0, 4'b0000, 4));

    reset = 1'b1;
    id_valid_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    id_reg_write_i = 0; ex_redirect_i = 0; mem_busy_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

    // reset while frozen with x7 pending
    run("rf.wr7",  mk(1, 0,0, 0,0, 7,1, 0,0, 4'b1000, 4));
    run("rf.busy", mk(1, 0,0, 0,0, 0,0, 0,1, 4'b0001, 4));
    step(mk(1, 7,1, 0,0, 0,0, 0,1, 4'b0000, 0), 1'b1);
    chk("rf.frz_in_rst", 16'(freeze_o), 16'd1);
    run("rf.after", mk(1, 7,1, 0,0, 0,0, 0,0, 4'b1000, 0));

    // reset while flushing
    run("rl.red", mk(1, 0,0, 0,0, 0,0, 1,0, 4'b0010, 0));
    step(mk(1, 0,0, 0,0, 0,0, 0,0, 4'b0000, 0), 1'b1);
    chk("rl.fl_in_rst", 16'(flush_o), 16'd1);
    run("rl.after", mk(1, 0,0, 0,0, 0,0, 0,0, 4'b1000, 0));

    // preload near saturation, then two RAW stall pairs
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("sat.preload", stall_cnt_o, 16'hFFFD);
    run("sat.w5",  mk(1, 0,0, 0,0, 5,1, 0,0, 4'b1000, 16'hFFFD));
    run("sat.s1",  mk(1, 5,1, 0,0, 5,1, 0,0, 4'b0100, 16'hFFFD));
    run("sat.s2",  mk(1, 5,1, 0,0, 5,1, 0,0, 4'b0100, 16'hFFFE));
    run("sat.i1",  mk(1, 5,1, 0,0, 5,1, 0,0, 4'b1000, 16'hFFFF));
    run("sat.s3",  mk(1, 5,1, 0,0, 0,0, 0,0, 4'b0100, 16'hFFFF));
    run("sat.s4",  mk(1, 5,1, 0,0, 0,0, 0,0, 4'b0100, 16'hFFFF));
    run("sat.i2",  mk(1, 5,1, 0,0, 0,0, 0,0, 4'b1000, 16'hFFFF));
    run("sat.end", mk(0, 0,0, 0,0, 0,0, 0,0, 4'b0000, 16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter PROC_REGFILE_LOG2_DEEP, default 5; register-index width; register file has 2**PROC_REGFILE_LOG2_DEEP entries.
REQ-002 Parameter WB_DIST, default 2; cycles from issue (ID->EX) until the result is readable from the register file; legal range 1-3.
REQ-003 Parameter FLUSH_CYCLES, default 2; number of cycles flush_o is held after a redirect; legal range 1-3.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 id_valid_i  input  1  ID holds a real instruction, not a bubble.
REQ-007 id_rs1_i, id_rs2_i  input  PROC_REGFILE_LOG2_DEEP each  ID source register indices.
REQ-008 id_use_rs1_i, id_use_rs2_i  input  1 each  the instruction actually reads rs1/rs2; suppresses false matches on immediate fields.
REQ-009 id_rd_i  input  PROC_REGFILE_LOG2_DEEP  ID destination register index.
REQ-010 id_reg_write_i  input  1  the ID instruction writes rd.
REQ-011 ex_redirect_i  input  1  branch taken, JAL or JALR resolved in EX this cycle.
REQ-012 mem_busy_i  input  1  data memory has not completed the access in MEM.
REQ-013 issue_o  output  1  the ID instruction advances to EX this cycle.
REQ-014 stall_o  output  1  hold PC and IF/ID; inject a NOP into ID/EX.
REQ-015 flush_o  output  1  squash IF/ID contents; load the redirect PC.
REQ-016 freeze_o  output  1  hold every pipeline register, including EX/MEM and MEM/WB.
REQ-017 stall_cnt_o  output  16  number of RAW stall cycles since reset; saturates at 16'hFFFF.

Function
REQ-018 Scoreboard: one 2-bit countdown counter pend[r] per register; pend[0] is always 0.
REQ-019 On issue_o with id_reg_write_i=1 and id_rd_i!=0, pend[id_rd_i] shall load WB_DIST on the next edge; this load overrides any decrement of the same entry.
REQ-020 When freeze_o=0, every other nonzero pend entry decrements by 1 per cycle; when freeze_o=1, all entries hold.
REQ-021 raw = id_valid_i & ((id_use_rs1_i & id_rs1_i!=0 & pend[id_rs1_i]!=0) | (id_use_rs2_i & id_rs2_i!=0 & pend[id_rs2_i]!=0)), computed combinationally from current state.
REQ-022 FSM states: RUN, FLUSH, FROZEN.
REQ-023 RUN: mem_busy_i=1 -> FROZEN (priority over redirect); else ex_redirect_i=1 -> FLUSH with flush counter = FLUSH_CYCLES-1; else stay in RUN.
REQ-024 FLUSH: flush_o=1 every cycle; mem_busy_i=1 -> FROZEN (counter held); a new ex_redirect_i reloads the counter; when the counter reaches 0 with no new redirect -> RUN.
REQ-025 FROZEN: freeze_o=1; ex_redirect_i is ignored; on mem_busy_i=0 return to the state that entered FROZEN, with the flush counter preserved.
REQ-026 flush_o = (state==FLUSH) | (state==RUN & ex_redirect_i & !mem_busy_i); the flush is visible in the redirect cycle itself.
REQ-027 freeze_o = mem_busy_i | (state==FROZEN & mem_busy_i); freeze_o drops in the same cycle mem_busy_i drops.
REQ-028 stall_o = raw & !flush_o & !freeze_o.
REQ-029 issue_o = id_valid_i & !raw & !flush_o & !freeze_o.
REQ-030 Outputs are mutually exclusive: at most one of issue_o, stall_o and flush_o is 1, and when freeze_o=1 all three are 0.
REQ-031 stall_cnt_o increments by 1 on each cycle with stall_o=1 and holds at 16'hFFFF.
REQ-032 A redirect kills only the not-yet-issued ID instruction; scoreboard entries from already-issued instructions keep counting down.

Reset
REQ-033 When reset=1 at an edge: all pend=0, state=RUN, flush counter=0, stall_cnt_o=0.
REQ-034 In the cycle after reset: issue_o=id_valid_i, stall_o=0, flush_o=0, freeze_o=0.
REQ-035 Reset asserted during FLUSH or FROZEN shall abort the sequence with no residual flush or freeze.

Verification
REQ-036 Back-to-back RAW: issue x5 write, then the next instruction reads x5 (use_rs1=1) -> stall_o=1 for 2 cycles, issue_o on the 3rd; stall_cnt_o=2.
REQ-037 False match: rs2=5 with id_use_rs2_i=0 while pend[5]=2 -> stall_o=0, issue_o=1; a write to x0 followed by a read of x0 -> no stall.
REQ-038 Redirect: ex_redirect_i pulse, FLUSH_CYCLES=2 -> flush_o=1 for exactly 2 cycles, issue_o=0 during both, return to RUN.
REQ-039 Freeze during flush: redirect, then mem_busy_i=1 for 3 cycles in the 2nd flush cycle -> freeze_o=1 for 3 cycles, pend values unchanged, then flush_o=1 for 1 more cycle.
REQ-040 Simultaneous events: ex_redirect_i, mem_busy_i and raw all 1 -> freeze_o=1, flush_o=0, stall_o=0; stall_cnt_o saturates at 16'hFFFF when preloaded near the limit by a long stall.
REQ-041 Reset mid-FROZEN with pend[7]=2 -> in the next cycle all outputs are 0 except issue_o, and a read of x7 does not stall.
